// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state encoding,
// opcode constants, datapath select codes and the per-state control word.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALADR   = 4'd10,
    S_JUMP     = 4'd11,
    S_UEXEC    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // result_src codes
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // alu_src_a codes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // alu_src_b codes
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // alu_op codes
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  // imm_src codes
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_UPPER,
    CLS_ILLEGAL
  } op_class_t;

  // Moore part of the control outputs. fetch/branch mark the two states whose
  // pc_write/ir_write are additionally gated by live inputs.
  typedef struct packed {
    logic       fetch;
    logic       branch;
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_word_t;

  // Control word for a given state; op_b5 distinguishes lui (1) from auipc (0).
  function automatic ctrl_word_t ctrl_decode(state_t s, logic op_b5);
    ctrl_word_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_RTYPE;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ITYPE;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.branch     = 1'b1;
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALU_BRANCH;
        c.result_src = RES_ALUOUT;
      end
      S_JALADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_JUMP: begin
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
      end
      S_UEXEC: begin
        c.alu_src_a = op_b5 ? SRCA_ZERO : SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of the instruction/handshake inputs and control outputs of the
// multicycle control unit. slave = control unit, master = datapath side.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_o;

  modport slave (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_read, mem_write, reg_write,
           illegal, result_src, alu_src_a, alu_src_b, alu_op, imm_src, state_o
  );

  modport master (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_read, mem_write, reg_write,
           illegal, result_src, alu_src_a, alu_src_b, alu_op, imm_src, state_o
  );
endinterface

// File: rtl/multicycle_control_opdec.sv
// Opcode decoder: instruction class for the FSM and immediate format for the
// immediate generator. Disabled instruction groups decode as illegal.
module ctrl_opdec
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned EN_JUMP  = 1,
  parameter int unsigned EN_UPPER = 1
) (
  input  logic [6:0] op,
  output op_class_t  op_class,
  output logic [2:0] imm_src
);

  // Classify the opcode; the immediate format follows the opcode alone.
  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_src  = IMM_I;
    case (op)
      OP_LOAD: begin
        op_class = CLS_LOAD;
        imm_src  = IMM_I;
      end
      OP_STORE: begin
        op_class = CLS_STORE;
        imm_src  = IMM_S;
      end
      OP_RTYPE: begin
        op_class = CLS_RTYPE;
      end
      OP_ITYPE: begin
        op_class = CLS_ITYPE;
        imm_src  = IMM_I;
      end
      OP_BRANCH: begin
        op_class = CLS_BRANCH;
        imm_src  = IMM_B;
      end
      OP_JAL: begin
        imm_src = IMM_J;
        if (EN_JUMP != 0) op_class = CLS_JAL;
      end
      OP_JALR: begin
        imm_src = IMM_I;
        if (EN_JUMP != 0) op_class = CLS_JALR;
      end
      OP_LUI, OP_AUIPC: begin
        imm_src = IMM_U;
        if (EN_UPPER != 0) op_class = CLS_UPPER;
      end
      default: begin
        op_class = CLS_ILLEGAL;
        imm_src  = IMM_I;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM. Select outputs and the Moore strobes are
// registered from the next state; pc_write/ir_write pick up mem_ready in
// FETCH and the branch outcome in BRANCH, and every strobe is forced low
// while reset is held.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned EN_JUMP  = 1,
  parameter int unsigned EN_UPPER = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.slave   bus
);

  op_class_t  op_class;
  logic [2:0] imm_src;

  state_t     state_q, state_d;
  ctrl_word_t ctrl_q, ctrl_d;

  ctrl_opdec #(
    .EN_JUMP  (EN_JUMP),
    .EN_UPPER (EN_UPPER)
  ) u_opdec (
    .op       (bus.op),
    .op_class (op_class),
    .imm_src  (imm_src)
  );

  // Next-state selection and the control word of the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_LOAD,
          CLS_STORE:  state_d = S_MEMADR;
          CLS_RTYPE:  state_d = S_EXECR;
          CLS_ITYPE:  state_d = S_EXECI;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JAL:    state_d = S_JUMP;
          CLS_JALR:   state_d = S_JALADR;
          CLS_UPPER:  state_d = S_UEXEC;
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALADR:   state_d = S_JUMP;
      S_JUMP:     state_d = S_ALUWB;
      S_UEXEC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_decode(state_d, bus.op[5]);
  end

  // State register and registered control word; reset lands in FETCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_decode(S_FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.pc_write   = rst & (ctrl_q.pc_write
                               | (ctrl_q.fetch  & bus.mem_ready)
                               | (ctrl_q.branch & (bus.zero ^ bus.funct3[0])));
  assign bus.ir_write   = rst & ctrl_q.fetch & bus.mem_ready;
  assign bus.mem_read   = rst & ctrl_q.mem_read;
  assign bus.mem_write  = rst & ctrl_q.mem_write;
  assign bus.reg_write  = rst & ctrl_q.reg_write;
  assign bus.illegal    = rst & ctrl_q.illegal;
  assign bus.adr_src    = ctrl_q.adr_src;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.imm_src    = imm_src;
  assign bus.state_o    = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter EN_JUMP, default 1: 1 = jal (1101111) and jalr (1100111) supported; 0 = treated as illegal.
REQ-002 Parameter EN_UPPER, default 1: 1 = lui (0110111) and auipc (0010111) supported; 0 = treated as illegal.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 op  in  7  opcode field of the instruction register.
REQ-006 funct3  in  3  instruction bits 14:12; bit 0 selects the branch sense.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory handshake; completes the current access.
REQ-009 Outputs, 1 bit each: pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, illegal.
REQ-010 Outputs, 2 bits each: result_src (00 ALUOut, 01 Data, 10 ALUResult), alu_src_a (00 PC, 01 OldPC, 10 rs1, 11 zero), alu_src_b (00 rs2, 01 imm, 10 const 4), alu_op (00 add, 01 branch compare, 10 R-type, 11 I-type).
REQ-011 imm_src  out  3  immediate format: I 000, S 001, B 010, J 011, U 100; combinational from op.
REQ-012 state_o  out  4  current state encoding, for debug.

Function
REQ-013 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALADR, JUMP, UEXEC, TRAP.
REQ-014 FETCH: adr_src 0, mem_read 1, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10; ir_write and pc_write only while mem_ready is high; hold FETCH until mem_ready, then go to DECODE.
REQ-015 DECODE: alu_src_a 01, alu_src_b 01, alu_op 00; next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JUMP
- 1100111 -> JALADR
- lui/auipc -> UEXEC
- any other op -> TRAP
REQ-016 MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00; next MEMREAD if op[5]=0, else MEMWRITE.
REQ-017 MEMREAD: adr_src 1, mem_read 1, result_src 00; hold until mem_ready, then MEMWB.
REQ-018 MEMWB: result_src 01, reg_write 1; next FETCH.
REQ-019 MEMWRITE: adr_src 1, result_src 00; mem_write asserted every cycle until and including the mem_ready cycle; then FETCH.
REQ-020 EXECR: alu_src_a 10, alu_src_b 00, alu_op 10; next ALUWB.
REQ-021 EXECI: alu_src_a 10, alu_src_b 01, alu_op 11; next ALUWB.
REQ-022 ALUWB: result_src 00, reg_write 1; next FETCH.
REQ-023 BRANCH: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00; pc_write = zero XOR funct3[0] (beq/bne); next FETCH.
REQ-024 JALADR: alu_src_a 10, alu_src_b 01, alu_op 00; next JUMP.
REQ-025 JUMP: result_src 00, pc_write 1, alu_src_a 01, alu_src_b 10, alu_op 00; next ALUWB.
REQ-026 UEXEC: alu_src_a 11 when op[5]=1 (lui) and 01 otherwise (auipc); alu_src_b 01, alu_op 00; next ALUWB.
REQ-027 TRAP: all strobes 0; illegal 1; remain in TRAP until reset.
REQ-028 Any select output not listed for a state SHALL be 00; any strobe not listed SHALL be 0.
REQ-029 Strobe outputs SHALL be Moore outputs of the state, gated only as stated (mem_ready in FETCH; zero/funct3 in BRANCH).
REQ-030 Latencies in cycles, with mem_ready=1: R/I/U 4, load 5, store 4, branch 3, jal 4, jalr 5.
REQ-031 mem_ready seen outside FETCH, MEMREAD or MEMWRITE SHALL be ignored.

Reset
REQ-032 When rst=0 at a rising edge, state SHALL become FETCH, from any state including mid-access and TRAP.
REQ-033 While rst=0, pc_write, ir_write, mem_read, mem_write and reg_write SHALL all be 0, and illegal SHALL be 0.
REQ-034 The first FETCH access SHALL begin the cycle after rst returns to 1.

Structure
REQ-035 Shared package riscv_ctrl_pkg SHALL hold the state encoding, opcode constants, and result_src, alu_src_a, alu_src_b, alu_op and imm_src codes.
REQ-036 A single combinational sub-module ctrl_opdec SHALL map op to the instruction class and imm_src; the FSM SHALL contain all sequential logic.

Verification
REQ-037 add (op 0110011), mem_ready=1: state sequence FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 in cycle 4 only.
REQ-038 lw (op 0000011) with mem_ready low 3 cycles in MEMREAD: MEMREAD held 4 cycles, then MEMWB with result_src 01 and reg_write 1.
REQ-039 bne (op 1100011, funct3 001): zero=0 gives pc_write=1 in BRANCH; zero=1 gives pc_write=0.
REQ-040 jalr (op 1100111) with EN_JUMP=1: FETCH, DECODE, JALADR, JUMP, ALUWB; with EN_JUMP=0: DECODE, TRAP, illegal=1 held.
REQ-041 rst=0 asserted in MEMWRITE while mem_ready=0: next state FETCH, mem_write=0 that cycle; TRAP is also cleared by reset.
